// File: rtl/sample_rle_packer_pkg.sv
// Shared definitions for the logic-analyser capture path.
//  REC_W         width of one run-length record {run_cnt, run_val}
//  BYTES_PER_REC bytes streamed per record, LSB first
//  RUN_MAX       largest repeat count a single record can carry
//  rle_rec_t     packed record layout as it sits in the FIFO
package sample_rle_packer_pkg;

  localparam int          REC_W         = 32;
  localparam int          BYTES_PER_REC = 4;
  localparam logic [15:0] RUN_MAX       = 16'hFFFF;
  localparam logic [1:0]  LAST_BYTE     = 2'(BYTES_PER_REC - 1);

  typedef struct packed {
    logic [15:0] cnt;  // extra repeats, 0 = seen once
    logic [15:0] val;  // sampled probe value
  } rle_rec_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous record FIFO.
//  clk_48, rst     clock and synchronous active-high reset
//  push, wr_data   write request; ignored when full
//  pop, rd_data    read request; rd_data shows the head entry (first-word fall-through)
//  full, empty     occupancy flags derived from level
//  level           number of entries held (0 .. 2**FIFO_AW)
module sample_fifo
  import sample_rle_packer_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int DW      = REC_W
) (
  input  logic              clk_48,
  input  logic              rst,
  input  logic              push,
  input  logic [DW-1:0]     wr_data,
  input  logic              pop,
  output logic [DW-1:0]     rd_data,
  output logic              full,
  output logic              empty,
  output logic [FIFO_AW:0]  level
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [DW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Full is judged on the occupancy before this cycle's pop, so a
  // simultaneous pop never makes room for a push.
  assign full    = (level == (FIFO_AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is read combinationally so the serializer can load it in the
  // same cycle it pops, which keeps the byte stream gap-free.
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk_48) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk_48) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{FIFO_AW{1'b0}}, do_push} - {{FIFO_AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/sample_rle_packer.sv
// Logic-analyser front end: samples 16 probe pins on a programmable strobe,
// run-length encodes them into 32-bit records, buffers the records and
// streams them out as bytes (LSB first) over a valid/ready handshake.
//  clk_48      system clock, only clock of the block
//  rst         synchronous active-high reset
//  enable      capture enable; falling edge flushes the open run
//  divider     strobe period minus 1
//  s_in        raw asynchronous probe pins
//  out_data    stream byte, out_valid qualifies it, out_ready accepts it
//  overflow    sticky record-dropped flag, cleared by rst or enable rising
//  fifo_level  records held in the FIFO
//  busy        open run, FIFO not empty or serializer active
module sample_rle_packer
  import sample_rle_packer_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic              clk_48,
  input  logic              rst,
  input  logic              enable,
  input  logic [15:0]       divider,
  input  logic [15:0]       s_in,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic [FIFO_AW:0]  fifo_level,
  output logic              busy
);

  logic [15:0]      s_meta;
  logic [15:0]      s_sync;
  logic [15:0]      cnt;
  logic             strobe;
  logic             enable_d;
  logic             run_open;
  logic [15:0]      run_val;
  logic [15:0]      run_cnt;
  logic             push;
  rle_rec_t         push_rec;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REC_W-1:0] head;
  logic [REC_W-1:0] shift_reg;
  logic [1:0]       byte_idx;

  // Two-flop synchronizer for the asynchronous probe pins.
  always_ff @(posedge clk_48) begin
    if (rst) begin
      s_meta <= '0;
      s_sync <= '0;
    end else begin
      s_meta <= s_in;
      s_sync <= s_meta;
    end
  end

  // Prescaler. An equality compare means a divider lowered below the
  // current count lets cnt run through 0xFFFF before the next strobe.
  assign strobe = enable && (cnt == divider);

  always_ff @(posedge clk_48) begin
    if (rst || !enable || strobe) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // A record leaves the encoder when the run is flushed by disable, or
  // when a strobe sees a new value or a saturated repeat count.
  assign push_rec = '{cnt: run_cnt, val: run_val};

  always_comb begin
    push = 1'b0;
    if (!enable) begin
      push = run_open;
    end else if (strobe && run_open &&
                 ((s_sync != run_val) || (run_cnt == RUN_MAX))) begin
      push = 1'b1;
    end
  end

  always_ff @(posedge clk_48) begin
    if (rst) begin
      run_open <= 1'b0;
      run_val  <= '0;
      run_cnt  <= '0;
    end else if (!enable) begin
      run_open <= 1'b0;
    end else if (strobe) begin
      if (!run_open || push) begin
        run_open <= 1'b1;
        run_val  <= s_sync;
        run_cnt  <= '0;
      end else begin
        run_cnt <= run_cnt + 16'd1;
      end
    end
  end

  // Sticky drop flag; a fresh capture session (enable rising) clears it.
  always_ff @(posedge clk_48) begin
    if (rst) begin
      enable_d <= 1'b0;
      overflow <= 1'b0;
    end else begin
      enable_d <= enable;
      if (enable && !enable_d) overflow <= 1'b0;
      if (push && fifo_full)   overflow <= 1'b1;
    end
  end

  sample_fifo #(
    .FIFO_AW (FIFO_AW),
    .DW      (REC_W)
  ) u_fifo (
    .clk_48  (clk_48),
    .rst     (rst),
    .push    (push),
    .wr_data (push_rec),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Serializer: the record is shifted right a byte per accepted beat, so
  // out_data is always the low byte of a register and holds while stalled.
  // The next record loads on the same edge the last byte is accepted.
  assign pop = !fifo_empty && (!out_valid || (out_ready && (byte_idx == LAST_BYTE)));

  always_ff @(posedge clk_48) begin
    if (rst) begin
      out_valid <= 1'b0;
      shift_reg <= '0;
      byte_idx  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      shift_reg <= head;
      byte_idx  <= '0;
    end else if (out_valid && out_ready) begin
      shift_reg <= shift_reg >> 8;
      byte_idx  <= byte_idx + 2'd1;
      if (byte_idx == LAST_BYTE) out_valid <= 1'b0;
    end
  end

  assign out_data = shift_reg[7:0];
  assign busy     = run_open || !fifo_empty || out_valid;

endmodule
